// File: rtl/batch_eval_ctrl.sv
// batch_eval_ctrl: streams each image from RAM into the classifier, waits for its verdict and scores it against the label RAM
module batch_eval_ctrl #(
  parameter int NUM_IMAGES  = 100,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int PIX_W       = 8,
  parameter int LBL_W       = 4,
  parameter int FLUSH_ROWS  = 15,
  parameter int TIMEOUT_CYC = 5000,
  parameter int DUT_RST_CYC = 5,
  parameter int SETTLE_CYC  = 10,
  parameter int GAP_CYC     = 10,
  parameter int CNT_W       = 16,
  localparam int NPIX = IMG_W * IMG_H,
  localparam int IA_W = (NUM_IMAGES * NPIX > 1) ? $clog2(NUM_IMAGES * NPIX) : 1,
  localparam int IX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             stop_on_fail,
  output logic             img_rd_en,
  output logic [IA_W-1:0]  img_addr,
  input  logic [PIX_W-1:0] img_rdata,
  output logic             lbl_rd_en,
  output logic [IX_W-1:0]  lbl_addr,
  input  logic [LBL_W-1:0] lbl_rdata,
  output logic             dut_rst_n,
  output logic             dut_in_valid,
  output logic [PIX_W-1:0] dut_in_data,
  input  logic             dut_class_valid,
  input  logic [LBL_W-1:0] dut_class_out,
  output logic             busy,
  output logic             done,
  output logic [IX_W-1:0]  cur_img,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             mis_valid,
  output logic [IX_W-1:0]  mis_img,
  output logic [LBL_W-1:0] mis_pred,
  output logic [LBL_W-1:0] mis_true,
  output logic             mis_timeout
);
  localparam int NTOT = (IMG_H + FLUSH_ROWS) * IMG_W;
  localparam int M0 = (TIMEOUT_CYC > NTOT) ? TIMEOUT_CYC : NTOT;
  localparam int M1 = (M0 > GAP_CYC) ? M0 : GAP_CYC;
  localparam int M2 = (M1 > DUT_RST_CYC) ? M1 : DUT_RST_CYC;
  localparam int M3 = (M2 > SETTLE_CYC) ? M2 : SETTLE_CYC;
  localparam int PC_W = $clog2(M3 + 1);
  localparam logic [PC_W-1:0] C_DRST = PC_W'(DUT_RST_CYC - 1);
  localparam logic [PC_W-1:0] C_SET  = PC_W'(SETTLE_CYC - 1);
  localparam logic [PC_W-1:0] C_GAP  = PC_W'(GAP_CYC - 1);
  localparam logic [PC_W-1:0] C_TMO  = PC_W'(TIMEOUT_CYC - 1);
  localparam logic [PC_W-1:0] C_PRE  = PC_W'(NPIX - 1);
  localparam logic [PC_W-1:0] C_NPIX = PC_W'(NPIX);
  localparam logic [PC_W-1:0] C_NTOT = PC_W'(NTOT);
  localparam logic [IX_W-1:0] C_LAST = IX_W'(NUM_IMAGES - 1);
  localparam logic [IA_W-1:0] C_STEP = IA_W'(NPIX);

  typedef enum logic [2:0] {IDLE, DRST, SETTLE, RUN, GAP, FIN} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  cnt_q, cnt_d;
  logic [IX_W-1:0]  cur_q, cur_d;
  logic [IA_W-1:0]  base_q, base_d, img_addr_q, img_addr_d;
  logic [LBL_W-1:0] lbl_q, lbl_d;
  logic             lbl_vld_q, lbl_vld_d;
  logic             sof_q, sof_d, bad_q, bad_d;
  logic [CNT_W-1:0] ok_q, ok_d, fl_q, fl_d, to_q, to_d;
  logic             mis_valid_q, mis_valid_d, mis_to_q, mis_to_d;
  logic [IX_W-1:0]  mis_img_q, mis_img_d;
  logic [LBL_W-1:0] mis_pred_q, mis_pred_d, mis_true_q, mis_true_d;
  logic             img_rd_en_q, img_rd_en_d, lbl_rd_en_q, lbl_rd_en_d;
  logic             dut_rst_n_q, dut_rst_n_d, in_vld_q, in_vld_d, in_pix_q, in_pix_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             hit, tmo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction

  // next state, scoring, and outputs derived from the upcoming state so every strobe leaves a flop
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    base_d      = base_q;
    sof_d       = sof_q;
    bad_d       = bad_q;
    lbl_vld_d   = lbl_rd_en_q;
    lbl_d       = lbl_vld_q ? lbl_rdata : lbl_q;
    ok_d        = ok_q;
    fl_d        = fl_q;
    to_d        = to_q;
    mis_valid_d = 1'b0;
    mis_img_d   = mis_img_q;
    mis_pred_d  = mis_pred_q;
    mis_true_d  = mis_true_q;
    mis_to_d    = mis_to_q;
    hit         = state_q == RUN && dut_class_valid;
    tmo         = state_q == RUN && !dut_class_valid && cnt_q == C_TMO;
    if (abort && state_q inside {DRST, SETTLE, RUN, GAP}) begin
      state_d = FIN;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d    = DRST;
          cur_d      = '0;
          base_d     = '0;
          sof_d      = stop_on_fail;
          bad_d      = 1'b0;
          ok_d       = '0;
          fl_d       = '0;
          to_d       = '0;
          mis_img_d  = '0;
          mis_pred_d = '0;
          mis_true_d = '0;
          mis_to_d   = 1'b0;
        end
        DRST: if (cnt_q == C_DRST) state_d = SETTLE;
        SETTLE: if (cnt_q == C_SET) state_d = RUN;
        RUN: if (hit || tmo) begin
          state_d     = GAP;
          mis_valid_d = !hit || dut_class_out != lbl_q;
          bad_d       = mis_valid_d;
          ok_d        = mis_valid_d ? ok_q : sat_inc(ok_q);
          fl_d        = (hit && mis_valid_d) ? sat_inc(fl_q) : fl_q;
          to_d        = hit ? to_q : sat_inc(to_q);
          if (mis_valid_d) begin
            mis_img_d  = cur_q;
            mis_pred_d = hit ? dut_class_out : '0;
            mis_true_d = lbl_q;
            mis_to_d   = !hit;
          end
        end
        GAP: if (cnt_q == C_GAP) begin
          if (cur_q == C_LAST || (sof_q && bad_q)) begin
            state_d = FIN;
          end else begin
            state_d = DRST;
            cur_d   = cur_q + 1'b1;
            base_d  = base_q + C_STEP;
            bad_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    cnt_d       = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    img_rd_en_d = (state_d == SETTLE && cnt_d == C_SET) || (state_d == RUN && cnt_d < C_PRE);
    img_addr_d  = !img_rd_en_d ? img_addr_q : (state_d == SETTLE) ? base_q : img_addr_q + 1'b1;
    lbl_rd_en_d = state_d == DRST && cnt_d == '0;
    dut_rst_n_d = state_d != DRST;
    in_vld_d    = state_d == RUN && cnt_d < C_NTOT;
    in_pix_d    = state_d == RUN && cnt_d < C_NPIX;
    busy_d      = state_d inside {DRST, SETTLE, RUN, GAP};
    done_d      = state_d == FIN;
  end

  // state, counters and registered outputs; reset parks the classifier in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      base_q      <= '0;
      img_addr_q  <= '0;
      lbl_q       <= '0;
      lbl_vld_q   <= 1'b0;
      sof_q       <= 1'b0;
      bad_q       <= 1'b0;
      ok_q        <= '0;
      fl_q        <= '0;
      to_q        <= '0;
      mis_valid_q <= 1'b0;
      mis_img_q   <= '0;
      mis_pred_q  <= '0;
      mis_true_q  <= '0;
      mis_to_q    <= 1'b0;
      img_rd_en_q <= 1'b0;
      lbl_rd_en_q <= 1'b0;
      dut_rst_n_q <= 1'b0;
      in_vld_q    <= 1'b0;
      in_pix_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      base_q      <= base_d;
      img_addr_q  <= img_addr_d;
      lbl_q       <= lbl_d;
      lbl_vld_q   <= lbl_vld_d;
      sof_q       <= sof_d;
      bad_q       <= bad_d;
      ok_q        <= ok_d;
      fl_q        <= fl_d;
      to_q        <= to_d;
      mis_valid_q <= mis_valid_d;
      mis_img_q   <= mis_img_d;
      mis_pred_q  <= mis_pred_d;
      mis_true_q  <= mis_true_d;
      mis_to_q    <= mis_to_d;
      img_rd_en_q <= img_rd_en_d;
      lbl_rd_en_q <= lbl_rd_en_d;
      dut_rst_n_q <= dut_rst_n_d;
      in_vld_q    <= in_vld_d;
      in_pix_q    <= in_pix_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign img_rd_en    = img_rd_en_q;
  assign img_addr     = img_addr_q;
  assign lbl_rd_en    = lbl_rd_en_q;
  assign lbl_addr     = cur_q;
  assign dut_rst_n    = dut_rst_n_q;
  assign dut_in_valid = in_vld_q;
  assign dut_in_data  = in_pix_q ? img_rdata : '0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_img      = cur_q;
  assign correct_cnt  = ok_q;
  assign fail_cnt     = fl_q;
  assign timeout_cnt  = to_q;
  assign mis_valid    = mis_valid_q;
  assign mis_img      = mis_img_q;
  assign mis_pred     = mis_pred_q;
  assign mis_true     = mis_true_q;
  assign mis_timeout  = mis_to_q;
endmodule

// File: tb/tb_batch_eval_ctrl.sv
// tb_batch_eval_ctrl: scoreboard bench driving directed batches through batch_eval_ctrl with a RAM and classifier model
module tb_batch_eval_ctrl;
  localparam int N = 4, W = 4, H = 4, PW = 8, LW = 4, FR = 2, TMO = 40, DR = 2, ST = 3, GP = 2, CW = 16;
  localparam int NPIX = W * H, NTOT = (H + FR) * W;

  typedef struct {int ok; int fl; int tm; int cur; int drst;} done_t;

  logic clk = 0, rst = 1, start = 0, abort = 0, stop_on_fail = 0;
  logic img_rd_en, lbl_rd_en, dut_rst_n, dut_in_valid, busy, done, mis_valid, mis_timeout;
  logic [5:0] img_addr;
  logic [1:0] lbl_addr, cur_img, mis_img;
  logic [PW-1:0] img_rdata = '0, dut_in_data;
  logic [LW-1:0] lbl_rdata = '0, mis_pred, mis_true;
  logic dut_class_valid = 0;
  logic [LW-1:0] dut_class_out = '0;
  logic [CW-1:0] correct_cnt, fail_cnt, timeout_cnt;

  logic [LW-1:0] labels [N] = '{4'd3, 4'd7, 4'd1, 4'd9};
  int resp_p [N];
  logic [LW-1:0] resp_c [N];
  int exp_pix[$];
  int exp_mis[$];
  done_t exp_done[$];
  bit pix_chk = 0;
  int drst_cnt = 0;
  int n_chk = 0, n_pass = 0;

  batch_eval_ctrl #(.NUM_IMAGES(N), .IMG_W(W), .IMG_H(H), .PIX_W(PW), .LBL_W(LW), .FLUSH_ROWS(FR),
    .TIMEOUT_CYC(TMO), .DUT_RST_CYC(DR), .SETTLE_CYC(ST), .GAP_CYC(GP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_fail(stop_on_fail),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
    .lbl_rd_en(lbl_rd_en), .lbl_addr(lbl_addr), .lbl_rdata(lbl_rdata),
    .dut_rst_n(dut_rst_n), .dut_in_valid(dut_in_valid), .dut_in_data(dut_in_data),
    .dut_class_valid(dut_class_valid), .dut_class_out(dut_class_out),
    .busy(busy), .done(done), .cur_img(cur_img),
    .correct_cnt(correct_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
    .mis_valid(mis_valid), .mis_img(mis_img), .mis_pred(mis_pred), .mis_true(mis_true), .mis_timeout(mis_timeout));

  always #5 clk = ~clk;

  // image RAM holds its own address as data; label RAM holds the fixed labels
  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= PW'(img_addr);
    if (lbl_rd_en) lbl_rdata <= labels[lbl_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int mis_code(input int img, input int pred, input int tru, input int to);
    return img * 512 + pred * 32 + tru * 2 + to;
  endfunction

  task automatic push_pix(input int nimg);
    for (int k = 0; k < nimg; k++) begin
      for (int i = 0; i < NPIX; i++) exp_pix.push_back(k * NPIX + i);
      for (int i = NPIX; i < NTOT; i++) exp_pix.push_back(0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, int'(|{busy, done, img_rd_en, img_addr, lbl_rd_en, lbl_addr, dut_in_valid, dut_in_data,
      cur_img, correct_cnt, fail_cnt, timeout_cnt, mis_valid, mis_img, mis_pred, mis_true, mis_timeout}), 0);
    chk({tag, "_rstn"}, int'(dut_rst_n), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_seen", 0, 1);
  endtask

  task automatic chk_left();
    repeat (3) @(negedge clk);
    chk("pix_left", exp_pix.size(), 0);
    chk("mis_left", exp_mis.size(), 0);
    chk("done_left", exp_done.size(), 0);
  endtask

  task automatic run_batch(input bit sof, input int nimg, input bit poke);
    drst_cnt = 0;
    push_pix(nimg);
    pix_chk = 1;
    stop_on_fail = sof;
    start = 1;
    @(negedge clk);
    start = 0;
    stop_on_fail = 0;
    if (poke) begin
      repeat (60) @(negedge clk);
      chk("busy_mid", int'(busy), 1);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done();
    chk_left();
    pix_chk = 0;
  endtask

  // classifier model: phase counts from the first valid pixel after each DUT reset
  initial begin
    int p;
    bit run;
    p = 0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!dut_rst_n || rst) begin
        run = 0;
        p = 0;
      end else if (run) p++;
      else if (dut_in_valid) begin
        run = 1;
        p = 0;
      end
      if (run && p >= NTOT) chk("valid_after_flush", int'(dut_in_valid), 0);
      dut_class_valid = run && p == resp_p[cur_img];
      dut_class_out = resp_c[cur_img];
    end
  end

  // pixel stream monitor
  initial forever begin
    @(negedge clk);
    if (dut_in_valid && pix_chk) begin
      if (exp_pix.size() == 0) chk("pix_extra", 1, 0);
      else chk("pix", int'(dut_in_data), exp_pix.pop_front());
    end
  end

  // mismatch report monitor
  initial forever begin
    @(negedge clk);
    if (mis_valid) begin
      if (exp_mis.size() == 0) chk("mis_extra", 1, 0);
      else chk("mis_entry", int'({mis_img, mis_pred, mis_true, mis_timeout}), exp_mis.pop_front());
    end
  end

  // batch end monitor
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_done.size() == 0) chk("done_extra", 1, 0);
        else begin
          e = exp_done.pop_front();
          chk("correct_cnt", int'(correct_cnt), e.ok);
          chk("fail_cnt", int'(fail_cnt), e.fl);
          chk("timeout_cnt", int'(timeout_cnt), e.tm);
          chk("cur_img", int'(cur_img), e.cur);
          chk("drst_count", drst_cnt, e.drst);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  // counts classifier reset assertions
  initial begin
    logic prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (prev && !dut_rst_n) drst_cnt++;
      prev = dut_rst_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, vcnt;
    resp_p = '{-1, -1, -1, -1};
    resp_c = '{4'd0, 4'd0, 4'd0, 4'd0};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    chk("rstn_after_reset", int'(dut_rst_n), 1);

    // every image times out: full pixel stream plus flush, four timeout reports
    for (int k = 0; k < N; k++) exp_mis.push_back(mis_code(k, 0, int'(labels[k]), 1));
    exp_done.push_back('{0, 0, 4, 3, 4});
    run_batch(0, 4, 0);

    // scoring with one wrong answer, plus a start pulse mid-batch that must be ignored
    resp_p = '{30, 30, 30, 30};
    resp_c = '{4'd3, 4'd7, 4'd2, 4'd9};
    exp_mis.push_back(mis_code(2, 2, 1, 0));
    exp_done.push_back('{3, 1, 0, 3, 4});
    run_batch(0, 4, 1);

    // answers on the timeout cycle and on the first post-flush cycle
    resp_p = '{39, 24, 30, 39};
    resp_c = '{4'd3, 4'd7, 4'd1, 4'd9};
    exp_done.push_back('{4, 0, 0, 3, 4});
    run_batch(0, 4, 0);

    // stop on the first failure at image 1
    resp_p = '{30, 30, 30, 30};
    resp_c = '{4'd3, 4'd8, 4'd1, 4'd9};
    exp_mis.push_back(mis_code(1, 8, 7, 0));
    exp_done.push_back('{1, 1, 0, 1, 2});
    run_batch(1, 2, 0);

    // abort in the pixel phase of image 2
    resp_c = '{4'd3, 4'd7, 4'd1, 4'd9};
    drst_cnt = 0;
    exp_done.push_back('{2, 0, 0, 2, 3});
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(cur_img == 2 && dut_in_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_run", int'(dut_in_valid), 1);
    abort = 1;
    @(negedge clk);
    chk("abort_done", int'(done), 1);
    chk("abort_valid", int'(dut_in_valid), 0);
    abort = 0;
    chk_left();

    // asynchronous reset in the flush rows of image 1, then a clean batch
    resp_p = '{30, -1, -1, -1};
    resp_c = '{4'd5, 4'd0, 4'd0, 4'd0};
    exp_mis.push_back(mis_code(0, 5, 3, 0));
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(cur_img == 1 && dut_in_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vcnt = 0;
    while (vcnt < 18 && n < 500) begin
      @(negedge clk);
      n++;
      if (dut_in_valid) vcnt++;
    end
    chk("reached_flush", vcnt, 18);
    chk("pre_reset_fail_cnt", int'(fail_cnt), 1);
    #2 rst = 1;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rstn_after_release", int'(dut_rst_n), 1);
    chk_left();
    resp_p = '{30, 30, 30, 30};
    resp_c = '{4'd3, 4'd7, 4'd2, 4'd9};
    exp_mis.push_back(mis_code(2, 2, 1, 0));
    exp_done.push_back('{3, 1, 0, 3, 4});
    run_batch(0, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/batch_eval_ctrl.md
Name: batch_eval_ctrl

Overview:
- Synthesizable on-chip batch evaluation engine for the CNN classifier top (`main`).
- Per image:
  - reads the image from an external image RAM and streams its pixels into the classifier;
  - appends zero-flush rows;
  - waits for the class result under a timeout;
  - scores the result against a label RAM.
- Replaces simulation-only batch scoring for FPGA accuracy runs.
- Generalised in image geometry, pixel/label width, batch size, flush depth, timeout, DUT reset and gap timing; adds stop-on-fail, abort, and a mismatch report stream.

Parameters:
- NUM_IMAGES, 100, images per batch (>=1)
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per image
- PIX_W, 8, pixel width
- LBL_W, 4, label/class width
- FLUSH_ROWS, 15, zero rows appended after each image
- TIMEOUT_CYC, 5000, max RUN cycles per image, counted from the first pixel
- DUT_RST_CYC, 5, cycles dut_rst_n is held low per image
- SETTLE_CYC, 10, cycles between DUT reset release and the first pixel
- GAP_CYC, 10, idle cycles after each image result
- CNT_W, 16, width of the result counters

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- start  in  1  1-cycle pulse; begins a batch when idle
- abort  in  1  level; ends the batch early
- stop_on_fail  in  1  sampled at start; halts the batch after the first fail or timeout
- img_rd_en  out  1  image RAM read strobe
- img_addr  out  clog2(NUM_IMAGES*IMG_W*IMG_H)  image RAM address
- img_rdata  in  PIX_W  image RAM data, valid 1 cycle after img_rd_en
- lbl_rd_en  out  1  label RAM read strobe
- lbl_addr  out  clog2(NUM_IMAGES) (min 1)  label RAM address
- lbl_rdata  in  LBL_W  label RAM data, valid 1 cycle after lbl_rd_en
- dut_rst_n  out  1  classifier reset, active-low
- dut_in_valid  out  1  pixel valid to the classifier
- dut_in_data  out  PIX_W  pixel to the classifier
- dut_class_valid  in  1  classifier result strobe
- dut_class_out  in  LBL_W  classifier predicted class
- busy  out  1  batch in progress
- done  out  1  1-cycle pulse at batch end
- cur_img  out  clog2(NUM_IMAGES) (min 1)  index of the image under test
- correct_cnt, fail_cnt, timeout_cnt  out  CNT_W  result counters, saturating
- mis_valid  out  1  1-cycle pulse per fail or timeout
- mis_img  out  clog2(NUM_IMAGES) (min 1)  image index of the fail or timeout
- mis_pred  out  LBL_W  predicted class; 0 on timeout
- mis_true  out  LBL_W  label of that image
- mis_timeout  out  1  1 = the reported entry is a timeout

Behaviour:
- Reset (rst high, asynchronous):
  - state IDLE; every output 0, except dut_rst_n = 0.
  - Reset mid-batch discards all progress.
  - After rst is released, dut_rst_n goes high the next cycle.
- FSM states: IDLE -> DRST -> SETTLE -> RUN -> GAP -> (DRST for the next image | FIN) -> IDLE.
- IDLE:
  - dut_rst_n = 1.
  - start clears all counters, sets cur_img = 0, latches stop_on_fail, sets busy, goes to DRST.
  - start is ignored while busy.
- DRST:
  - dut_rst_n = 0 for DUT_RST_CYC cycles.
  - Label read for cur_img is issued in the first cycle; the label is latched into an internal register.
- SETTLE:
  - dut_rst_n = 1 for SETTLE_CYC cycles.
  - Image address cur_img*IMG_W*IMG_H is read in the last SETTLE cycle (prefetch).
- RUN (phase counter p = 0,1,2,…):
  - p < IMG_W*IMG_H: dut_in_valid = 1, dut_in_data = img_rdata for pixel p. Address of pixel p+1 is issued in the same cycle. No bubbles.
  - p < (IMG_H+FLUSH_ROWS)*IMG_W: dut_in_valid = 1, dut_in_data = 0.
  - After that: dut_in_valid = 0, dut_in_data = 0.
  - dut_class_valid = 1 in any RUN cycle:
    - dut_class_out == label: correct_cnt + 1.
    - otherwise: fail_cnt + 1 and mis_valid pulse with mis_timeout = 0.
    - dut_in_valid drops the next cycle; go to GAP.
  - p == TIMEOUT_CYC-1 with no dut_class_valid: timeout_cnt + 1, mis_valid with mis_timeout = 1, go to GAP.
  - Result and timeout in the same cycle: the result wins; no timeout is counted.
- dut_class_valid outside RUN is ignored; any further strobe after the first in one image is ignored.
- GAP: all DUT inputs low for GAP_CYC cycles. Then:
  - cur_img == NUM_IMAGES-1, or a fail/timeout occurred with stop_on_fail latched: go to FIN.
  - otherwise: cur_img + 1, go to DRST.
- abort high in DRST, SETTLE, RUN, or GAP: go to FIN next cycle; the current image is not scored.
- FIN: done = 1 for one cycle, busy = 0, dut_in_valid = 0, go to IDLE. Counters and the mis_* fields hold until the next start.
- Counters saturate at 2^CNT_W-1.
- Invariant at done without abort or stop: correct + fail + timeout = NUM_IMAGES.

Test Plan:
- Bench config: NUM_IMAGES=4, IMG_W=IMG_H=4, FLUSH_ROWS=2, TIMEOUT_CYC=40, DUT_RST_CYC=2, SETTLE_CYC=3, GAP_CYC=2.
- Stream check: pixel RAM = address value, model never responds -> per image 16 valid pixels 0x00..0x0F (+16·img), then 8 zeros, then valid low. 4 timeouts, each mis_timeout = 1; timeout_cnt = 4; done pulses once.
- Scoring: labels 3,7,1,9; model answers 3,7,2,9 at p=30 -> correct = 3, fail = 1; mis_img = 2, mis_pred = 2, mis_true = 1.
- Boundary race: model answers correctly exactly at p=39 -> counted correct, timeout_cnt = 0. Answer at p=24 (first post-flush cycle) -> dut_in_valid = 0 from p=24 onward.
- stop_on_fail = 1, image 1 mismatches -> done after image 1; cur_img = 1, correct = 1, fail = 1, no DRST for image 2.
- Control: abort asserted in RUN of image 2 -> done next cycle, counts cover images 0-1 only. start pulse while busy -> no effect.
- Reset: rst pulsed mid-flush -> all outputs 0 and dut_rst_n = 0 immediately. A new start afterwards runs a clean batch from image 0.
